// File: rtl/demux_1ton_hs.sv
// demux_1ton_hs: registered 1-to-NCH demultiplexer, valid/ready handshake.
// Each channel holds one word in its own output register.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   producer handshake (in_ready is combinational)
//   in_data, in_sel  input word and destination channel index
//   out_valid/ready  per-channel consumer handshake, bit k = channel k
//   out_data         channel k word at [k*WIDTH +: WIDTH]
//   oob_cnt          saturating count of dropped out-of-range selects
// Optional feature macro: DEMUX_BCAST_EN adds in_bcast, which writes
// the accepted word to every channel at once.
module demux_1ton_hs #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
`ifdef DEMUX_BCAST_EN
    input  logic                 in_bcast,
`endif
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [7:0]           oob_cnt
);

    logic bcast;
`ifdef DEMUX_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    // room[k]: channel k can take a word this cycle (empty or draining)
    logic [NCH-1:0]   room;
    logic [NCH-1:0]   hit;
    logic [NCH-1:0]   wr_en;
    logic             sel_ok;
    logic             sel_room;
    logic             acc;
    logic             oob_hit;
    logic [WIDTH-1:0] data_q [NCH];

    assign room = ~out_valid | out_ready;

    // One-hot select decode; all-zero when in_sel is out of range,
    // which happens only when NCH is not a power of two.
    always_comb begin
        hit = '0;
        for (int k = 0; k < NCH; k++) begin
            hit[k] = (in_sel == SELW'(k));
        end
    end

    assign sel_ok   = |hit;
    assign sel_room = |(hit & room);

    // Out-of-range words are always accepted and discarded.
    assign in_ready = bcast ? (&room) : (~sel_ok | sel_room);
    assign acc      = in_valid & in_ready;

    always_comb begin
        wr_en = '0;
        if (acc) begin
            wr_en = bcast ? {NCH{1'b1}} : hit;
        end
    end

    assign oob_hit = acc & ~bcast & ~sel_ok;

    // A write wins over a same-cycle drain, keeping the channel valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            for (int k = 0; k < NCH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            out_valid <= wr_en | (out_valid & ~out_ready);
            for (int k = 0; k < NCH; k++) begin
                if (wr_en[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < NCH; k++) begin
            out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_cnt <= '0;
        end else if (oob_hit && (oob_cnt != 8'hFF)) begin
            oob_cnt <= oob_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_demux_1ton_hs.sv
// tb_demux_1ton_hs: self-checking bench for demux_1ton_hs.
// Drives an NCH=4 and an NCH=3 instance; random phase uses a queue model.
module tb_demux_1ton_hs;

    logic clk = 1'b0;
    logic rst_n;

    logic        in_valid4, in_ready4;
    logic [7:0]  in_data4;
    logic [1:0]  in_sel4;
    logic [3:0]  out_valid4, out_ready4;
    logic [31:0] out_data4;
    logic [7:0]  oob4;

    logic        in_valid3, in_ready3;
    logic [7:0]  in_data3;
    logic [1:0]  in_sel3;
    logic [2:0]  out_valid3, out_ready3;
    logic [23:0] out_data3;
    logic [7:0]  oob3;

`ifdef DEMUX_BCAST_EN
    logic        in_bcast4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // expected contents: last written word and undelivered words per channel
    logic [7:0] last [4];
    logic [7:0] q [4][$];

    always #5 clk = ~clk;

    demux_1ton_hs #(.WIDTH(8), .NCH(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .in_sel(in_sel4),
`ifdef DEMUX_BCAST_EN
        .in_bcast(in_bcast4),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .oob_cnt(oob4)
    );

    demux_1ton_hs #(.WIDTH(8), .NCH(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .in_sel(in_sel3),
`ifdef DEMUX_BCAST_EN
        .in_bcast(1'b0),
`endif
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .oob_cnt(oob3)
    );

    task automatic idle();
        in_valid4 = 1'b0; in_sel4 = '0; in_data4 = '0; out_ready4 = '0;
        in_valid3 = 1'b0; in_sel3 = '0; in_data3 = '0; out_ready3 = '0;
`ifdef DEMUX_BCAST_EN
        in_bcast4 = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b1; in_sel4 = 2'd1; in_data4 = 8'h11;
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'h22;
        @(posedge clk); #1;
        idle();
        n_checks++;
        if (out_valid4 !== 4'b0010) begin
            n_fail++;
            $display("FAIL pre_rst_valid: got %b want %b", out_valid4, 4'b0010);
        end
        n_checks++;
        if (oob3 !== 8'd1) begin
            n_fail++;
            $display("FAIL pre_rst_oob: got %0d want 1", oob3);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid4, out_data4, oob4} !== '0) begin
            n_fail++;
            $display("FAIL rst_u4: got v=%b d=%h c=%0d want 0",
                     out_valid4, out_data4, oob4);
        end
        n_checks++;
        if ({out_valid3, out_data3, oob3} !== '0) begin
            n_fail++;
            $display("FAIL rst_u3: got v=%b d=%h c=%0d want 0",
                     out_valid3, out_data3, oob3);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_rst_valid: got %b want 0000", out_valid4);
        end
    endtask

    task automatic test_hold();
        in_valid4 = 1'b1; in_sel4 = 2'd2; in_data4 = 8'hA5; out_ready4 = '0;
        #1;
        n_checks++;
        if (in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_rdy_empty: got %b want 1", in_ready4);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b0100 || out_data4[23:16] !== 8'hA5) begin
            n_fail++;
            $display("FAIL hold_write: got v=%b d=%h want 0100/a5",
                     out_valid4, out_data4[23:16]);
        end
        in_data4 = 8'h5A;
        #1;
        n_checks++;
        if (in_ready4 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_rdy_full: got %b want 0", in_ready4);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b0100 || out_data4[23:16] !== 8'hA5) begin
            n_fail++;
            $display("FAIL hold_stall: got v=%b d=%h want 0100/a5",
                     out_valid4, out_data4[23:16]);
        end
        out_ready4 = 4'b0100;
        #1;
        n_checks++;
        if (in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_rdy_release: got %b want 1", in_ready4);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b0100 || out_data4[23:16] !== 8'h5A) begin
            n_fail++;
            $display("FAIL hold_second: got v=%b d=%h want 0100/5a",
                     out_valid4, out_data4[23:16]);
        end
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b0000 || out_data4[23:16] !== 8'h5A) begin
            n_fail++;
            $display("FAIL hold_drain: got v=%b d=%h want 0000/5a",
                     out_valid4, out_data4[23:16]);
        end
        idle();
        last[2] = 8'h5A;
    endtask

    task automatic test_drain_write();
        in_valid4 = 1'b1; in_sel4 = 2'd1; in_data4 = 8'h11; out_ready4 = '0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b0010) begin
            n_fail++;
            $display("FAIL dw_fill: got %b want 0010", out_valid4);
        end
        in_data4 = 8'h3C; out_ready4 = 4'b0010;
        #1;
        n_checks++;
        if (in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL dw_rdy: got %b want 1", in_ready4);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b0010 || out_data4[15:8] !== 8'h3C) begin
            n_fail++;
            $display("FAIL dw_write: got v=%b d=%h want 0010/3c",
                     out_valid4, out_data4[15:8]);
        end
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b0000 || out_data4[15:8] !== 8'h3C) begin
            n_fail++;
            $display("FAIL dw_drain: got v=%b d=%h want 0000/3c",
                     out_valid4, out_data4[15:8]);
        end
        idle();
        last[1] = 8'h3C;
    endtask

    task automatic test_oob_saturate();
        int e;
        for (int i = 0; i < 300; i++) begin
            in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'($urandom);
            #1;
            n_checks++;
            if (in_ready3 !== 1'b1) begin
                n_fail++;
                $display("FAIL oob_rdy[%0d]: got %b want 1", i, in_ready3);
            end
            @(posedge clk); #1;
            e = (i + 1 > 255) ? 255 : i + 1;
            n_checks++;
            if (oob3 !== 8'(e)) begin
                n_fail++;
                $display("FAIL oob_cnt[%0d]: got %0d want %0d", i, oob3, e);
            end
            n_checks++;
            if ({out_valid3, out_data3} !== '0) begin
                n_fail++;
                $display("FAIL oob_chan[%0d]: got v=%b d=%h want 0",
                         i, out_valid3, out_data3);
            end
        end
        in_sel3 = 2'd2; in_data3 = 8'h42;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid3 !== 3'b100 || out_data3[23:16] !== 8'h42
            || oob3 !== 8'd255) begin
            n_fail++;
            $display("FAIL oob_inrange: got v=%b d=%h c=%0d want 100/42/255",
                     out_valid3, out_data3[23:16], oob3);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        out_ready4 = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            w = 8'($urandom);
            in_valid4 = 1'b1; in_sel4 = 2'd0; in_data4 = w;
            #1;
            n_checks++;
            if (in_ready4 !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_rdy[%0d]: got %b want 1", i, in_ready4);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid4 !== 4'b0001 || out_data4[7:0] !== w) begin
                n_fail++;
                $display("FAIL b2b_word[%0d]: got v=%b d=%h want 0001/%h",
                         i, out_valid4, out_data4[7:0], w);
            end
        end
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b0000 || out_data4[7:0] !== w) begin
            n_fail++;
            $display("FAIL b2b_drain: got v=%b d=%h want 0000/%h",
                     out_valid4, out_data4[7:0], w);
        end
        idle();
        last[0] = w;
        last[3] = 8'h00;
    endtask

    task automatic test_random();
        int s;
        logic exp_rdy;
        logic acc_prev;
        logic [7:0] e;
        acc_prev = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!(in_valid4 && !acc_prev)) begin
                in_valid4 = ($urandom_range(0, 3) != 0);
                in_sel4   = 2'($urandom);
                in_data4  = 8'($urandom);
            end
            out_ready4 = 4'($urandom);
            #1;
            s = int'(in_sel4);
            exp_rdy = (q[s].size() == 0) || out_ready4[s];
            n_checks++;
            if (in_ready4 !== exp_rdy) begin
                n_fail++;
                $display("FAIL rnd_rdy[%0d]: got %b want %b",
                         c, in_ready4, exp_rdy);
            end
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && out_ready4[k]) begin
                    e = q[k].pop_front();
                    n_checks++;
                    if (out_data4[k*8 +: 8] !== e) begin
                        n_fail++;
                        $display("FAIL rnd_deliver[%0d] ch%0d: got %h want %h",
                                 c, k, out_data4[k*8 +: 8], e);
                    end
                end
            end
            acc_prev = in_valid4 && exp_rdy;
            if (acc_prev) begin
                q[s].push_back(in_data4);
                last[s] = in_data4;
            end
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (out_valid4[k] !== (q[k].size() != 0)
                    || out_data4[k*8 +: 8] !== last[k]) begin
                    n_fail++;
                    $display("FAIL rnd_state[%0d] ch%0d: got v=%b d=%h want %b/%h",
                             c, k, out_valid4[k], out_data4[k*8 +: 8],
                             q[k].size() != 0, last[k]);
                end
            end
        end
        idle();
        out_ready4 = 4'b1111;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) q[k].delete();
        n_checks++;
        if (out_valid4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL rnd_drain: got %b want 0000", out_valid4);
        end
        idle();
    endtask

`ifdef DEMUX_BCAST_EN
    task automatic test_bcast();
        in_valid4 = 1'b1; in_sel4 = 2'd3; in_data4 = 8'h33; out_ready4 = '0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b1000) begin
            n_fail++;
            $display("FAIL bc_fill: got %b want 1000", out_valid4);
        end
        in_bcast4 = 1'b1; in_sel4 = 2'd1; in_data4 = 8'h77;
        #1;
        n_checks++;
        if (in_ready4 !== 1'b0) begin
            n_fail++;
            $display("FAIL bc_rdy_blocked: got %b want 0", in_ready4);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b1000 || out_data4[31:24] !== 8'h33) begin
            n_fail++;
            $display("FAIL bc_stall: got v=%b d=%h want 1000/33",
                     out_valid4, out_data4[31:24]);
        end
        out_ready4 = 4'b1000;
        #1;
        n_checks++;
        if (in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL bc_rdy_release: got %b want 1", in_ready4);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b1111 || out_data4 !== {4{8'h77}}
            || oob4 !== 8'd0) begin
            n_fail++;
            $display("FAIL bc_write: got v=%b d=%h c=%0d want 1111/77777777/0",
                     out_valid4, out_data4, oob4);
        end
        idle();
        out_ready4 = 4'b1111;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL bc_drain: got %b want 0000", out_valid4);
        end
        idle();
    endtask
`endif

    initial begin
        for (int k = 0; k < 4; k++) last[k] = 8'h00;
        test_reset();
        test_hold();
        test_drain_write();
        test_oob_saturate();
        test_back_to_back();
        test_random();
`ifdef DEMUX_BCAST_EN
        test_bcast();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
